instr_issue_queue: RTL and testbench

INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

---
 rtl/instr_issue_queue_pkg.sv | 15 +
 rtl/instr_issue_queue_issue_fifo.sv | 56 +++++
 rtl/instr_issue_queue.sv | 123 ++++++++++++
 tb/tb_instr_issue_queue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/instr_issue_queue_pkg.sv
// Shared types and constants for the instruction issue queue and its power-mode governor.
package instr_issue_queue_pkg;

  localparam int   OPCODE_W = 3;
  localparam logic MODE_LP  = 1'b0;
  localparam logic MODE_HP  = 1'b1;

  typedef enum logic [1:0] {
    GOV_LP    = 2'd0,
    GOV_SW_UP = 2'd1,
    GOV_HP    = 2'd2,
    GOV_SW_DN = 2'd3
  } gov_state_e;

endpackage

// File: rtl/instr_issue_queue_issue_fifo.sv
// Show-ahead FIFO storage for the issue queue: pointers, entry count and opcode array.
module issue_fifo
  import instr_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [OPCODE_W-1:0]   wdata_i,
  input  logic                  pop_i,
  output logic [OPCODE_W-1:0]   head_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [OPCODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue with occupancy-driven LP/HP mode governor.
// Optional ISSUE_Q_STATS_EN adds a saturating 16-bit switch_count output.
module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HI_THRESH   = 6,
  parameter int LO_THRESH   = 1,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [OPCODE_W-1:0]    in_opcode,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [OPCODE_W-1:0]    out_opcode,
  input  logic                   out_ready,
  output logic                   mode,
  output logic                   mode_switching,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef ISSUE_Q_STATS_EN
  ,
  output logic [15:0]            switch_count
`endif
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  gov_state_e        state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              mode_q, switching_q;
  logic              push, pop, empty, full;
  logic              hi_cond, lo_cond, hold_done, up_fire, dn_fire;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (in_opcode),
    .pop_i   (pop),
    .head_o  (out_opcode),
    .empty_o (empty),
    .full_o  (full),
    .count_o (occupancy)
  );

  assign in_ready       = !full;
  assign out_valid      = !empty && !switching_q;
  assign mode           = mode_q;
  assign mode_switching = switching_q;

  assign hi_cond   = (occupancy >= CNT_W'(HI_THRESH));
  assign lo_cond   = (occupancy <= CNT_W'(LO_THRESH));
  assign hold_done = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  assign up_fire   = (state_q == GOV_LP) && hi_cond && hold_done;
  assign dn_fire   = (state_q == GOV_HP) && lo_cond && hold_done;

  // Mode only flips when leaving a bubble state, so it never changes under a valid issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GOV_LP;
      hold_q      <= '0;
      mode_q      <= MODE_LP;
      switching_q <= 1'b0;
    end else begin
      case (state_q)
        GOV_LP: begin
          if (up_fire) begin
            state_q     <= GOV_SW_UP;
            hold_q      <= '0;
            switching_q <= 1'b1;
          end else if (hi_cond) begin
            hold_q <= hold_q + 1'b1;
          end else begin
            hold_q <= '0;
          end
        end
        GOV_SW_UP: begin
          state_q     <= GOV_HP;
          hold_q      <= '0;
          mode_q      <= MODE_HP;
          switching_q <= 1'b0;
        end
        GOV_HP: begin
          if (dn_fire) begin
            state_q     <= GOV_SW_DN;
            hold_q      <= '0;
            switching_q <= 1'b1;
          end else if (lo_cond) begin
            hold_q <= hold_q + 1'b1;
          end else begin
            hold_q <= '0;
          end
        end
        default: begin
          state_q     <= GOV_LP;
          hold_q      <= '0;
          mode_q      <= MODE_LP;
          switching_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ISSUE_Q_STATS_EN
  logic [15:0] switch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      switch_count_q <= '0;
    else if ((up_fire || dn_fire) && (switch_count_q != 16'hFFFF))
      switch_count_q <= switch_count_q + 1'b1;
  end

  assign switch_count = switch_count_q;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: opcode scoreboard plus a cycle model of occupancy and governor.
module tb_instr_issue_queue;
  import instr_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int HI    = 6;
  localparam int LO    = 1;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid, out_ready;
  logic [2:0] in_opcode;
  logic       in_ready, out_valid, mode, mode_switching;
  logic [2:0] out_opcode;
  logic [3:0] occupancy;
`ifdef ISSUE_Q_STATS_EN
  logic [15:0] switch_count;
`endif

  instr_issue_queue #(.DEPTH(DEPTH), .HI_THRESH(HI), .LO_THRESH(LO), .HOLD_CYCLES(HOLD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_opcode      (in_opcode),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_opcode     (out_opcode),
    .out_ready      (out_ready),
    .mode           (mode),
    .mode_switching (mode_switching),
    .occupancy      (occupancy)
`ifdef ISSUE_Q_STATS_EN
    ,
    .switch_count   (switch_count)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] sb[$];
  int         m_gov  = 0;   // 0 LP, 1 SW_UP, 2 HP, 3 SW_DN
  int         m_hold = 0;
  int         m_swc  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_occupancy", occupancy, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_opcode", out_opcode, 0);
    check_val("rst_mode", mode, MODE_LP);
    check_val("rst_mode_switching", mode_switching, 0);
    check_val("rst_in_ready", in_ready, 1);
`ifdef ISSUE_Q_STATS_EN
    check_val("rst_switch_count", switch_count, 0);
`endif
    sb.delete();
    m_gov = 0; m_hold = 0; m_swc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a falling edge: drive, check pre-edge outputs, advance the model, wait one cycle.
  task automatic step(input logic v, input logic [2:0] op, input logic rdy);
    int   occ0;
    logic exp_ov;
    logic [2:0] popped;
    in_valid = v; in_opcode = op; out_ready = rdy;
    #1;
    occ0   = sb.size();
    exp_ov = (occ0 != 0) && (m_gov % 2 == 0);
    check_val("occupancy", occupancy, occ0);
    check_val("in_ready", in_ready, occ0 < DEPTH);
    check_val("out_valid", out_valid, exp_ov);
    check_val("mode", mode, m_gov >= 2);
    check_val("mode_switching", mode_switching, m_gov % 2);
    check_val("out_opcode", out_opcode, (occ0 == 0) ? 3'd0 : sb[0]);
`ifdef ISSUE_Q_STATS_EN
    check_val("switch_count", switch_count, m_swc);
`endif
    if (exp_ov && rdy) popped = sb.pop_front();
    if (v && occ0 < DEPTH) sb.push_back(op);
    case (m_gov)
      0: if (occ0 >= HI) begin
           m_hold++;
           if (m_hold == HOLD) begin m_gov = 1; m_hold = 0; m_swc++; end
         end else m_hold = 0;
      1: begin m_gov = 2; m_hold = 0; end
      2: if (occ0 <= LO) begin
           m_hold++;
           if (m_hold == HOLD) begin m_gov = 3; m_hold = 0; m_swc++; end
         end else m_hold = 0;
      default: begin m_gov = 0; m_hold = 0; end
    endcase
    @(negedge clk);
  endtask

  initial begin
    in_valid = 1'b0; in_opcode = 3'd0; out_ready = 1'b0;
    #2;
    apply_reset();

    // short stream with a ready consumer
    step(1, 3'd1, 1); step(1, 3'd2, 1); step(1, 3'd3, 1);
    repeat (3) step(0, 3'd0, 1);

    // fill to full, drop a ninth push, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 3'(i), 0);
    check_val("full_in_ready", in_ready, 0);
    step(1, 3'd7, 0);
    repeat (16) step(0, 3'd0, 1);

    // full with push attempt and pop: pop only, then next push accepted
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 3'(7 - i), 0);
    repeat (3) step(1, 3'd5, 1);
    step(1, 3'd6, 0);
    repeat (16) step(0, 3'd0, 1);

    // three cycles at threshold then drop below: no switch; then a real switch up and down
    apply_reset();
    for (int i = 0; i < 6; i++) step(1, 3'(i + 1), 0);
    step(0, 3'd0, 0); step(0, 3'd0, 0); step(0, 3'd0, 1);
    repeat (3) step(0, 3'd0, 0);
    check_val("near_miss_mode", mode, MODE_LP);
    step(1, 3'd2, 0);
    repeat (4) step(0, 3'd0, 0);
    check_val("sw_up_bubble", mode_switching, 1);
    step(1, 3'd3, 1);
    check_val("hp_mode", mode, MODE_HP);
    repeat (16) step(0, 3'd0, 1);
    check_val("lp_after_dn", mode, MODE_LP);
`ifdef ISSUE_Q_STATS_EN
    check_val("switch_count_two", switch_count, 2);
`endif

    // random traffic
    apply_reset();
    repeat (250) step(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 3) != 0));
    repeat (40) step(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 3) == 0));

    // reset during SW_UP with five entries queued
    apply_reset();
    for (int i = 0; i < 6; i++) step(1, 3'(i), 0);
    repeat (3) step(0, 3'd0, 0);
    step(0, 3'd0, 1);
    check_val("pre_rst_sw_up", mode_switching, m_gov == 1);
    check_val("pre_rst_occ", occupancy, 5);
    apply_reset();
    repeat (3) step(1, 3'd4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
